// File: rtl/character_animation_controller_pkg.sv
// Pose and face encodings shared by the animation sequencer and the display controller.
package char_anim_pkg;

    localparam int ID_WIDTH = 3;

    typedef enum logic [ID_WIDTH-1:0] {
        IDLE_1         = 3'd0,
        IDLE_2         = 3'd1,
        CHARGE         = 3'd2,
        JUMP_UP        = 3'd3,
        JUMP_DOWN      = 3'd4,
        FALL_TO_GROUND = 3'd5,
        SAFE_GROUND    = 3'd6
    } pose_e;

    localparam logic [1:0] FACE_RIGHT = 2'b01;
    localparam logic [1:0] FACE_LEFT  = 2'b11;

    function automatic logic is_airborne(pose_e p);
        return (p == JUMP_UP) || (p == JUMP_DOWN);
    endfunction

    function automatic logic is_hold(pose_e p);
        return (p == FALL_TO_GROUND) || (p == SAFE_GROUND);
    endfunction

    function automatic logic is_idle(pose_e p);
        return (p == IDLE_1) || (p == IDLE_2);
    endfunction

endpackage

// File: rtl/character_animation_controller_if.sv
// Physics-state inputs and pose outputs between the game logic and the animation sequencer.
interface character_animation_controller_if #(
    parameter int VEL_WIDTH = 10
);
    import char_anim_pkg::*;

    logic                        frame_tick;
    logic                        on_ground;
    logic                        charging;
    logic signed [VEL_WIDTH-1:0] vel_y;
    logic signed [1:0]           move_dir;
    logic [ID_WIDTH-1:0]         char_id;
    logic signed [1:0]           char_face;

    modport master (
        output frame_tick, on_ground, charging, vel_y, move_dir,
        input  char_id, char_face
    );

    modport slave (
        input  frame_tick, on_ground, charging, vel_y, move_dir,
        output char_id, char_face
    );

endinterface

// File: rtl/character_animation_controller_frame_counter.sv
// Loadable frame down-counter; advances only on frame ticks and saturates at zero.
module anim_frame_counter #(
    parameter int                   CNT_WIDTH = 6,
    parameter logic [CNT_WIDTH-1:0] RST_VAL   = '0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 tick,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt <= RST_VAL;
        end else if (tick) begin
            if (load) begin
                cnt <= load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/character_animation_controller.sv
// Per-frame pose sequencer: maps ground contact, vertical velocity, charge and direction to char_id/char_face.
module character_animation_controller
    import char_anim_pkg::*;
#(
    parameter int VEL_WIDTH    = 10,
    parameter int IDLE_PERIOD  = 30,
    parameter int LAND_HOLD    = 8,
    parameter int FALL_HOLD    = 30,
    parameter int HARD_FALL_VY = 12,
    parameter int CNT_WIDTH    = 6
) (
    input logic sys_clk,
    input logic sys_rst,
    character_animation_controller_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] IDLE_LOAD = CNT_WIDTH'(IDLE_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] LAND_LOAD = CNT_WIDTH'(LAND_HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] FALL_LOAD = CNT_WIDTH'(FALL_HOLD - 1);
    localparam logic signed [VEL_WIDTH-1:0] HARD_VY = VEL_WIDTH'(HARD_FALL_VY);

    pose_e                       state, state_next;
    logic signed [VEL_WIDTH-1:0] peak_vy, peak_next;
    logic [1:0]                  face, face_next;
    logic                        cnt_load;
    logic [CNT_WIDTH-1:0]        cnt_load_val;
    logic                        cnt_zero;
    logic                        vel_neg, vel_pos;

    assign vel_neg = bus.vel_y[VEL_WIDTH-1];
    assign vel_pos = !vel_neg && (bus.vel_y != '0);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE_1;
            peak_vy <= '0;
            face    <= FACE_RIGHT;
        end else if (bus.frame_tick) begin
            state   <= state_next;
            peak_vy <= peak_next;
            face    <= face_next;
        end
    end

    always_comb begin
        state_next   = state;
        peak_next    = peak_vy;
        cnt_load     = 1'b0;
        cnt_load_val = IDLE_LOAD;
        face_next    = ((bus.move_dir == FACE_RIGHT) || (bus.move_dir == FACE_LEFT)) ? bus.move_dir : face;

        if (state > SAFE_GROUND) begin
            state_next = IDLE_1;
            cnt_load   = 1'b1;
        end else if (!bus.on_ground) begin
            state_next = vel_neg ? JUMP_UP : JUMP_DOWN;
            // Peak is only meaningful from the second airborne frame onward.
            if (!is_airborne(state)) begin
                peak_next = '0;
            end else if (vel_pos && (bus.vel_y > peak_vy)) begin
                peak_next = bus.vel_y;
            end
        end else if (is_airborne(state)) begin
            cnt_load = 1'b1;
            if (peak_vy >= HARD_VY) begin
                state_next   = FALL_TO_GROUND;
                cnt_load_val = FALL_LOAD;
            end else begin
                state_next   = SAFE_GROUND;
                cnt_load_val = LAND_LOAD;
            end
        end else if (is_hold(state) && !cnt_zero) begin
            state_next = state;
        end else if (bus.charging) begin
            state_next = CHARGE;
        end else if (is_idle(state)) begin
            if (cnt_zero) begin
                state_next = (state == IDLE_1) ? IDLE_2 : IDLE_1;
                cnt_load   = 1'b1;
            end
        end else begin
            state_next = IDLE_1;
            cnt_load   = 1'b1;
        end
    end

    anim_frame_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .RST_VAL   (IDLE_LOAD)
    ) u_frame_counter (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .tick      (bus.frame_tick),
        .load      (cnt_load),
        .load_val  (cnt_load_val),
        .zero      (cnt_zero)
    );

    assign bus.char_id   = state;
    assign bus.char_face = face;

endmodule

// File: tb/tb_character_animation_controller.sv
// Directed bench for the animation sequencer: idle blink, charge, soft/hard landings, hold abort, face, reset.
module tb_character_animation_controller;
    import char_anim_pkg::*;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    character_animation_controller_if #(.VEL_WIDTH(10)) bus ();

    character_animation_controller #(
        .VEL_WIDTH    (10),
        .IDLE_PERIOD  (30),
        .LAND_HOLD    (8),
        .FALL_HOLD    (30),
        .HARD_FALL_VY (12),
        .CNT_WIDTH    (6)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge sys_clk);
        bus.frame_tick = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst        = 1'b1;
        bus.frame_tick = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst        = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    function automatic int id_now();
        return int'(bus.char_id);
    endfunction

    function automatic int face_now();
        return int'({bus.char_face});
    endfunction

    logic signed [9:0] jump_vy  [4];
    int                jump_exp [4];

    initial begin
        bus.frame_tick = 1'b0;
        bus.on_ground  = 1'b1;
        bus.charging   = 1'b0;
        bus.vel_y      = '0;
        bus.move_dir   = 2'b00;
        jump_vy  = '{-10'sd5, -10'sd1, 10'sd3, 10'sd8};
        jump_exp = '{3, 3, 4, 4};

        repeat (2) @(posedge sys_clk);
        do_reset();
        check_val("reset_id", id_now(), 0);
        check_val("reset_face", face_now(), 1);

        // idle blink: the pose shown after tick k is the one displayed during frame k+1
        for (int k = 0; k < 65; k++) begin
            do_tick();
            check_val("idle_id", id_now(), ((k + 1) / 30) % 2);
        end
        check_val("idle_face", face_now(), 1);

        repeat (5) do_tick();
        check_val("pre_charge", id_now(), 0);
        bus.charging = 1'b1;
        do_tick();
        check_val("charge", id_now(), 2);
        bus.charging = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_val("charge_between_ticks", id_now(), 2);
        do_tick();
        check_val("charge_release", id_now(), 0);

        bus.on_ground = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.vel_y = jump_vy[i];
            do_tick();
            check_val("jump_id", id_now(), jump_exp[i]);
        end
        bus.on_ground = 1'b1;
        bus.vel_y     = '0;
        do_tick();
        check_val("soft_land", id_now(), 6);
        for (int i = 1; i < 8; i++) begin
            do_tick();
            check_val("soft_hold", id_now(), 6);
        end
        do_tick();
        check_val("soft_exit", id_now(), 0);

        bus.on_ground = 1'b0;
        bus.vel_y     = 10'sd5;
        do_tick();
        check_val("hard_air0", id_now(), 4);
        bus.vel_y = 10'sd12;
        do_tick();
        check_val("hard_air1", id_now(), 4);
        bus.on_ground = 1'b1;
        bus.vel_y     = '0;
        bus.charging  = 1'b1;
        do_tick();
        check_val("hard_land", id_now(), 5);
        for (int i = 1; i < 30; i++) begin
            do_tick();
            check_val("hard_hold", id_now(), 5);
        end
        do_tick();
        check_val("hard_exit_charge", id_now(), 2);

        bus.charging = 1'b0;
        do_tick();
        check_val("back_idle", id_now(), 0);
        bus.on_ground = 1'b0;
        bus.vel_y     = 10'sd3;
        do_tick();
        bus.vel_y = 10'sd15;
        do_tick();
        check_val("abort_air", id_now(), 4);
        bus.on_ground = 1'b1;
        bus.vel_y     = '0;
        do_tick();
        check_val("abort_land", id_now(), 5);
        do_tick();
        check_val("abort_hold", id_now(), 5);
        bus.on_ground = 1'b0;
        bus.vel_y     = -10'sd4;
        bus.move_dir  = 2'b11;
        do_tick();
        check_val("abort_jump", id_now(), 3);
        check_val("face_left", face_now(), 3);
        bus.move_dir = 2'b00;
        do_tick();
        check_val("face_none", face_now(), 3);
        bus.move_dir = 2'b10;
        do_tick();
        check_val("face_invalid", face_now(), 3);
        bus.move_dir = 2'b01;
        do_tick();
        check_val("face_right", face_now(), 1);
        bus.move_dir = 2'b11;
        do_tick();
        check_val("face_left_again", face_now(), 3);
        bus.move_dir = 2'b00;

        bus.on_ground = 1'b1;
        bus.vel_y     = '0;
        do_tick();
        check_val("rst_hold_entry", id_now(), 6);
        do_tick();
        check_val("rst_hold_stay", id_now(), 6);
        bus.charging = 1'b1;
        do_reset();
        check_val("midhold_rst_id", id_now(), 0);
        check_val("midhold_rst_face", face_now(), 1);
        repeat (4) @(posedge sys_clk);
        #1;
        check_val("no_tick_hold", id_now(), 0);
        do_tick();
        check_val("post_rst_charge", id_now(), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/character_animation_controller.md
# character_animation_controller

Per-frame animation sequencer directly upstream of the character display controller. It converts physics state (ground contact, vertical velocity, charge request, move direction) into the registered `char_id` and `char_face` consumed by the display controller. All updates happen only on `frame_tick`, which debounces `char_id` and stops sprites from changing mid-scan. It also times idle blinking and landing poses.

## Interface
- `VEL_WIDTH`, 10: width of signed `vel_y`.
- `IDLE_PERIOD`, 30: frames per idle pose before toggling IDLE_1/IDLE_2; minimum 1.
- `LAND_HOLD`, 8: frames SAFE_GROUND is shown after a soft landing; minimum 1.
- `FALL_HOLD`, 30: frames FALL_TO_GROUND is shown after a hard landing; minimum 1.
- `HARD_FALL_VY`, 12: peak downward speed at or above which a landing is hard.
- `CNT_WIDTH`, 6: frame counter width; must hold max(IDLE_PERIOD, LAND_HOLD, FALL_HOLD) - 1.
- `sys_clk`  in  1  sole clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame, issued in vertical blank.
- `on_ground`  in  1  character is standing on a platform.
- `charging`  in  1  jump charge held.
- `vel_y`  in  VEL_WIDTH signed  vertical velocity; negative means moving up the screen.
- `move_dir`  in  2 signed  01 = right, 11 = left, 00 = none, 10 = invalid.
- `char_id`  out  3  pose ID (IDLE_1=0, IDLE_2=1, CHARGE=2, JUMP_UP=3, JUMP_DOWN=4, FALL_TO_GROUND=5, SAFE_GROUND=6); registered.
- `char_face`  out  2 signed  01 right, 11 left; registered.

## Operation
- State register is the pose itself; `char_id` = state. Codes 7 are unreachable and recover to IDLE_1.
- All state, counter, peak and face updates occur only in cycles where `frame_tick`=1. Other cycles hold everything.
- Priority per tick, highest first:
  - `!on_ground`:
    - `vel_y < 0` -> JUMP_UP; otherwise JUMP_DOWN.
    - Peak tracking: `peak_vy` is cleared on the first airborne tick. After that, `peak_vy` = max(`peak_vy`, `vel_y`) whenever `vel_y > 0`.
    - Going airborne aborts any hold immediately.
  - `on_ground`, previous state JUMP_UP/JUMP_DOWN (landing):
    - `peak_vy >= HARD_FALL_VY` -> FALL_TO_GROUND, `cnt = FALL_HOLD-1`.
    - Otherwise -> SAFE_GROUND, `cnt = LAND_HOLD-1`.
    - `charging` is ignored on the landing tick.
  - In FALL_TO_GROUND/SAFE_GROUND:
    - `cnt != 0` -> decrement and stay. `charging` is ignored.
    - `cnt == 0` -> leave the hold, evaluated as the grounded rules below.
  - Grounded, no hold active, `charging` -> CHARGE.
  - Grounded, no hold active, no charge -> idle:
    - Entry from any non-idle state -> IDLE_1, `cnt = IDLE_PERIOD-1`.
    - While idle: `cnt == 0` toggles IDLE_1<->IDLE_2 and reloads `IDLE_PERIOD-1`; otherwise decrement.
- Face update, on each tick:
  - `move_dir` 01 or 11 -> `char_face <= move_dir`.
  - 00 or 10 -> hold.
  - Face is updated in every state, including airborne.

## Timing
- Reset values: `char_id` = 0 (IDLE_1), `char_face` = 01, `cnt` = IDLE_PERIOD-1, `peak_vy` = 0.
- Latency: inputs are sampled in the `frame_tick` cycle; outputs change on the next `sys_clk` edge and stay stable until the next tick.
- Hold lengths:
  - A hold shows its pose for exactly HOLD ticks, including the entry tick.
  - Each idle pose is shown for exactly IDLE_PERIOD ticks.
- `frame_tick` held high continuously: every cycle counts as a frame; no special handling.
- Reset asserted mid-hold or mid-air returns to the reset values on the next edge and overrides `frame_tick`.
- Simultaneous `!on_ground` and `charging`: airborne wins.

## Structure
- Shared package `char_anim_pkg`:
  - the 3-bit pose ID constants and width;
  - the face encodings FACE_RIGHT=2'b01 and FACE_LEFT=2'b11.
  - The display controller imports the same package.
- One sub-module `anim_frame_counter`:
  - loadable down-counter of CNT_WIDTH;
  - inputs: `tick`, `load`, `load_val`; output: `zero`.

## Test plan
- Reset, then `on_ground`=1 and 65 ticks with IDLE_PERIOD=30 -> `char_id` 0 for ticks 0–29, 1 for ticks 30–59, 0 from tick 60; `char_face`=01.
- Grounded, `charging`=1 at tick 5 -> `char_id`=2 one cycle after tick 5. Release `charging` -> `char_id`=0 after the next tick.
- Airborne with `vel_y` sequence -5, -1, 3, 8, then land -> `char_id` 3, 3, 4, 4, then 6 for exactly 8 ticks, then 0.
- Airborne with peak `vel_y`=12, then land with `charging`=1 -> `char_id`=5 for 30 ticks ignoring the charge, then 2.
- During a FALL_TO_GROUND hold, `on_ground` drops with `vel_y`=-4 -> `char_id`=3 on the next tick. `move_dir` 11, 00, 10 -> `char_face` 11, 11, 11.
- Assert `sys_rst` mid-hold for one cycle with `frame_tick`=1 -> `char_id`=0 and `char_face`=01 on the next edge. No update between ticks.
